// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: zero-fills r0..r31 after reset, then arbitrates ALU (alu_*) and load (ld_*) writebacks onto the registered rf_* write port, load-first with ALU starvation bound MAX_WAIT
module regfile_write_scheduler #(
  parameter bit CLEAR_EN = 1'b1,
  parameter bit DROP_R0 = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_write_data,
  output logic        rf_reg_write,
  output logic        init_done
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [0:0] CLEAR = 1'b0, RUN = 1'b1;
  logic [0:0] state_q, state_d;
  logic [4:0] clr_q, clr_d, rd_q, rd_d, g_rd;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0] data_q, data_d, g_data;
  logic we_q, we_d, init_q, init_d, en, alu_win, grant, clr_st;
  assign en = state_q == RUN && init_q;
  assign alu_win = alu_valid && (!ld_valid || wait_q == WMAX);
  assign alu_ready = en && alu_win;
  assign ld_ready = en && ld_valid && !alu_win;
  assign rf_rd = rd_q;
  assign rf_write_data = data_q;
  assign rf_reg_write = we_q;
  assign init_done = init_q;
  always_comb begin
    clr_st = state_q == CLEAR;
    grant = alu_ready || ld_ready;
    g_rd = alu_ready ? alu_rd : ld_rd;
    g_data = alu_ready ? alu_data : ld_data;
    state_d = clr_st && clr_q == 5'd31 ? RUN : state_q;
    clr_d = clr_st ? clr_q + 5'd1 : clr_q;
    init_d = clr_st ? clr_q == 5'd31 : 1'b1;
    wait_d = !en ? wait_q : (!alu_valid || alu_ready) ? '0 : wait_q == WMAX ? wait_q : wait_q + 1'b1;
    rd_d = clr_st ? clr_q : grant ? g_rd : rd_q;
    data_d = clr_st ? '0 : grant ? g_data : data_q;
    we_d = clr_st || (grant && !(DROP_R0 && g_rd == 5'd0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_EN ? CLEAR : RUN;
      clr_q <= '0;
      wait_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      wait_q <= wait_d;
      rd_q <= rd_d;
      data_q <= data_d;
      we_q <= we_d;
      init_q <= init_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: scenario and randomized checks of the write scheduler against a shadow register model
module tb_regfile_write_scheduler;
  localparam int MW = 4;
  logic clk = 0, reset = 1;
  logic alu_valid = 0, ld_valid = 0, alu_ready, ld_ready, rf_reg_write, init_done;
  logic [4:0] alu_rd = 0, ld_rd = 0, rf_rd;
  logic [31:0] alu_data = 0, ld_data = 0, rf_write_data;
  logic b_reset = 1, b_alu_valid = 0, b_ld_valid = 0, b_alu_ready, b_ld_ready, b_rf_reg_write, b_init_done;
  logic [4:0] b_alu_rd = 0, b_ld_rd = 0, b_rf_rd;
  logic [31:0] b_alu_data = 0, b_ld_data = 0, b_rf_write_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regfile_write_scheduler #(.CLEAR_EN(1'b1), .DROP_R0(1'b1), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write), .init_done(init_done));
  regfile_write_scheduler #(.CLEAR_EN(1'b0), .DROP_R0(1'b0), .MAX_WAIT(MW)) u_alt (
    .clk(clk), .reset(b_reset), .alu_valid(b_alu_valid), .alu_rd(b_alu_rd), .alu_data(b_alu_data),
    .alu_ready(b_alu_ready), .ld_valid(b_ld_valid), .ld_rd(b_ld_rd), .ld_data(b_ld_data), .ld_ready(b_ld_ready),
    .rf_rd(b_rf_rd), .rf_write_data(b_rf_write_data), .rf_reg_write(b_rf_reg_write), .init_done(b_init_done));
  task drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
             input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
    #1;
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task test_no_clear;
    tick;
    total++; if (b_init_done !== 0 || b_rf_reg_write !== 0) begin bad++; $display("FAIL alt_reset init=%b we=%b want 0 0", b_init_done, b_rf_reg_write); end
    b_reset = 0;
    @(negedge clk); b_ld_valid = 1; b_ld_rd = 0; b_ld_data = 32'h1234; #1;
    total++; if (b_ld_ready !== 0) begin bad++; $display("FAIL alt_ready_before_init got %b want 0", b_ld_ready); end
    tick;
    total++; if (b_init_done !== 1 || b_rf_reg_write !== 0) begin bad++; $display("FAIL alt_init init=%b we=%b want 1 0", b_init_done, b_rf_reg_write); end
    @(negedge clk); #1;
    total++; if (b_ld_ready !== 1 || b_alu_ready !== 0) begin bad++; $display("FAIL alt_ld_ready ld=%b alu=%b want 1 0", b_ld_ready, b_alu_ready); end
    tick;
    total++; if (b_rf_reg_write !== 1 || b_rf_rd !== 0 || b_rf_write_data !== 32'h1234) begin
      bad++; $display("FAIL alt_r0_write we=%b rd=%0d data=%h want 1 0 00001234", b_rf_reg_write, b_rf_rd, b_rf_write_data); end
    @(negedge clk); b_ld_valid = 0;
  endtask
  task test_clear;
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'd3, 32'hFFFF_FFFF, 1, 5'd4, 32'hEEEE_EEEE);
      total++; if (alu_ready !== 0 || ld_ready !== 0) begin bad++; $display("FAIL clear_ready step %0d alu=%b ld=%b want 0 0", i, alu_ready, ld_ready); end
      tick;
      total++; if (rf_rd !== 5'(i) || rf_write_data !== 0 || rf_reg_write !== 1 || init_done !== (i == 31)) begin
        bad++; $display("FAIL clear_step %0d rd=%0d data=%h we=%b init=%b want rd=%0d 0 1 %0d", i, rf_rd, rf_write_data, rf_reg_write, init_done, i, i == 31); end
    end
  endtask
  task test_reset;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    total++; if (rf_rd !== 0 || rf_write_data !== 0 || rf_reg_write !== 0 || init_done !== 0) begin
      bad++; $display("FAIL reset_state rd=%0d data=%h we=%b init=%b want 0 0 0 0", rf_rd, rf_write_data, rf_reg_write, init_done); end
    test_clear;
  endtask
  task test_alu_only;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    total++; if (alu_ready !== 1 || ld_ready !== 0) begin bad++; $display("FAIL alu_only_ready alu=%b ld=%b want 1 0", alu_ready, ld_ready); end
    tick;
    total++; if (rf_rd !== 5 || rf_write_data !== 32'hDEADBEEF || rf_reg_write !== 1) begin
      bad++; $display("FAIL alu_only_write rd=%0d data=%h we=%b want 5 deadbeef 1", rf_rd, rf_write_data, rf_reg_write); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (alu_ready !== 0 || ld_ready !== 0) begin bad++; $display("FAIL idle_ready alu=%b ld=%b want 0 0", alu_ready, ld_ready); end
    tick;
    total++; if (rf_reg_write !== 0 || rf_rd !== 5 || rf_write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL idle_hold rd=%0d data=%h we=%b want 5 deadbeef 0", rf_rd, rf_write_data, rf_reg_write); end
  endtask
  task test_back_to_back;
    logic [31:0] ad;
    logic [4:0] lr;
    logic ea;
    ad = 32'hA000_0000; lr = 1;
    for (int c = 0; c < 15; c++) begin
      drive(1, 5'd7, ad, 1, lr, 32'hB000_0000 + 32'(lr));
      ea = (c % 5) == 4;
      total++; if (alu_ready !== ea || ld_ready !== !ea) begin bad++; $display("FAIL b2b_grant cycle %0d alu=%b ld=%b want %b %b", c, alu_ready, ld_ready, ea, !ea); end
      tick;
      total++; if (rf_reg_write !== 1 || rf_rd !== (ea ? 5'd7 : lr) || rf_write_data !== (ea ? ad : 32'hB000_0000 + 32'(lr))) begin
        bad++; $display("FAIL b2b_write cycle %0d rd=%0d data=%h we=%b", c, rf_rd, rf_write_data, rf_reg_write); end
      if (ea) ad = ad + 1; else lr = lr + 1;
    end
  endtask
  task test_drop_r0;
    drive(0, 0, 0, 1, 5'd0, 32'h1234);
    total++; if (ld_ready !== 1 || alu_ready !== 0) begin bad++; $display("FAIL drop_ready ld=%b alu=%b want 1 0", ld_ready, alu_ready); end
    tick;
    total++; if (rf_reg_write !== 0 || rf_rd !== 0 || rf_write_data !== 32'h1234) begin
      bad++; $display("FAIL drop_r0 we=%b rd=%0d data=%h want 0 0 00001234", rf_reg_write, rf_rd, rf_write_data); end
  endtask
  task test_random;
    logic [31:0] shadow [32], mirror [32];
    logic av, lv, ea, el, ewe;
    logic [4:0] ar, lr, erd;
    logic [31:0] ad, ldd, edat;
    int st, stall;
    for (int i = 0; i < 32; i++) begin shadow[i] = 0; mirror[i] = 0; end
    av = 0; lv = 0; ar = 0; lr = 0; ad = 0; ldd = 0; st = 0; stall = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!av) begin av = 1'($urandom_range(0, 1)); ar = 5'($urandom); ad = $urandom; end
      if (!lv) begin lv = 1'($urandom_range(0, 2) != 0); lr = 5'($urandom); ldd = $urandom; end
      drive(av, ar, ad, lv, lr, ldd);
      ea = av && (!lv || st == MW);
      el = lv && !ea;
      total++; if (alu_ready !== ea || ld_ready !== el) begin bad++; $display("FAIL rnd_grant cycle %0d alu=%b ld=%b want %b %b", c, alu_ready, ld_ready, ea, el); end
      total++; if (alu_ready && ld_ready) begin bad++; $display("FAIL rnd_both_ready cycle %0d got 1 1 want at most one", c); end
      stall = (alu_valid && !alu_ready) ? stall + 1 : 0;
      total++; if (stall > MW) begin bad++; $display("FAIL rnd_starve cycle %0d stall=%0d want <=%0d", c, stall, MW); end
      st = (!av || ea) ? 0 : (st < MW ? st + 1 : MW);
      erd = ea ? ar : lr;
      edat = ea ? ad : ldd;
      ewe = (ea || el) && erd != 0;
      tick;
      total++; if (rf_reg_write !== ewe) begin bad++; $display("FAIL rnd_we cycle %0d got %b want %b", c, rf_reg_write, ewe); end
      if (ea || el) begin
        total++; if (rf_rd !== erd || rf_write_data !== edat) begin bad++; $display("FAIL rnd_addr_data cycle %0d rd=%0d data=%h want %0d %h", c, rf_rd, rf_write_data, erd, edat); end
      end
      if (ewe) shadow[erd] = edat;
      if (rf_reg_write) mirror[rf_rd] = rf_write_data;
      if (ea) av = 0;
      if (el) lv = 0;
    end
    for (int i = 0; i < 32; i++) begin
      total++; if (mirror[i] !== shadow[i]) begin bad++; $display("FAIL rnd_shadow r%0d got %h want %h", i, mirror[i], shadow[i]); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
  endtask
  task test_mid_reset;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    reset = 0;
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick;
      total++; if (rf_rd !== 5'(i) || rf_reg_write !== 1) begin bad++; $display("FAIL mid_pre step %0d rd=%0d we=%b want %0d 1", i, rf_rd, rf_reg_write, i); end
    end
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    total++; if (rf_reg_write !== 0 || init_done !== 0 || rf_rd !== 0) begin
      bad++; $display("FAIL mid_clear_reset we=%b init=%b rd=%0d want 0 0 0", rf_reg_write, init_done, rf_rd); end
    test_clear;
    drive(1, 5'd9, 32'h55, 0, 0, 0);
    reset = 1;
    tick;
    total++; if (rf_reg_write !== 0 || init_done !== 0 || rf_rd !== 0) begin
      bad++; $display("FAIL mid_run_reset we=%b init=%b rd=%0d want 0 0 0", rf_reg_write, init_done, rf_rd); end
    test_clear;
    test_alu_only;
  endtask
  initial begin
    test_no_clear;
    test_reset;
    test_alu_only;
    test_back_to_back;
    test_drop_r0;
    test_random;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
